vu_frame_scheduler: RTL and testbench
=====================================

Name: vu_frame_scheduler

Overview:
Frame-level sequencer in front of npxl_controller for the VU meter strip. Collects audio level samples and, at a fixed frame rate, converts the loudest sample into a bar graph with a peak-hold dot. It issues the one-cycle send strobe to the driver, then streams one 24-bit GRB word per pixel over a valid/ready handshake. It is the only block that starts driver transfers.

Parameters:
CLK_HZ, 50_000_000, system clock frequency
FRAME_HZ, 60, frame refresh rate; TICK_DIV = CLK_HZ/FRAME_HZ cycles per frame tick
NUM_PIXELS, 16, LEDs on the strip (>=2)
LEVEL_W, 8, level sample width
PEAK_HOLD_FRAMES, 30, frames the peak dot holds before decaying

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_level  in  LEVEL_W  unsigned level sample
i_level_valid  in  1  i_level valid this cycle
i_enable  in  1  meter enable
i_drv_rdy  in  1  driver idle and able to accept a frame
o_drv_send  out  1  one-cycle frame start strobe to driver
o_pix_data  out  24  pixel colour, GRB order, G in [23:16]
o_pix_valid  out  1  o_pix_data valid
i_pix_ready  in  1  driver accepts pixel word
o_frame_busy  out  1  high from LATCH through DONE
o_frame_cnt  out  16  completed frames, wraps at 0xFFFF

Behaviour:
- Reset (async, any state): all outputs 0, FSM in IDLE, accumulator/peak/hold/tick counter 0, pending 0, blank_req 0.
- Tick counter counts 0..TICK_DIV-1 and pulses tick at wrap. It free-runs regardless of FSM state.
- Accumulator: on i_level_valid, acc <= max(acc, i_level). In the LATCH cycle, acc <= (i_level_valid ? i_level : 0), so a sample in that cycle belongs to the next window.
- FSM states: IDLE, LATCH, WAIT_RDY, STREAM, DONE.
- IDLE -> LATCH on tick when i_enable=1, or when blank_req=1.
- LATCH, 1 cycle: snapshot lit = ((acc+1)*NUM_PIXELS) >> LEVEL_W, width clog2(NUM_PIXELS+1). Level 0 gives 0; all-ones gives NUM_PIXELS. Update peak, then go to WAIT_RDY.
- Peak update, once per LATCH (non-blank frames only):
  - If lit >= peak: peak <= lit, hold <= PEAK_HOLD_FRAMES.
  - Else if hold > 0: hold--.
  - Else if peak > 0: peak-- (one pixel per frame).
- WAIT_RDY: when i_drv_rdy=1, assert o_drv_send for exactly one cycle and enter STREAM with idx=0. Waits indefinitely otherwise.
- STREAM:
  - o_pix_valid=1; o_pix_data = colour(idx).
  - On valid&ready, idx++. After idx=NUM_PIXELS-1 is accepted, go to DONE.
  - While valid&!ready, o_pix_data must remain stable.
  - First o_pix_valid is the cycle after o_drv_send.
- Colour(i), first match wins:
  - Blank frame: 0x000000.
  - i < lit and i < NUM_PIXELS*5/8: green 0x100000.
  - i < lit and i < NUM_PIXELS*7/8: yellow 0x101000.
  - i < lit: red 0x001000.
  - i == peak-1 and peak > 0: peak dot 0x080808.
  - Otherwise: 0x000000.
- DONE, 1 cycle: o_frame_cnt++. Next state is LATCH if pending (or blank_req) is set, else IDLE. pending clears on that transition.
- Tick while busy (LATCH..DONE) and enabled sets pending. Multiple ticks collapse into one; extra ticks are dropped.
- i_enable falling edge: sets blank_req. An in-progress frame completes normally, then exactly one blank frame is sent. Peak state is unchanged by the blank frame. No further frames are sent while i_enable=0.
- If i_enable rises before the blank frame is sent: blank_req clears and normal scheduling resumes.
- o_frame_busy = (state != IDLE).

Decomposition:
- Package vu_pkg holds:
  - FSM state enum.
  - GRB colour constants: COL_GREEN, COL_YELLOW, COL_RED, COL_PEAK, COL_OFF.
  - Zone fraction constants: 5/8 and 7/8.
  - Function computing lit from level.
- Sub-module vu_peak_tracker: peak and hold registers plus the update rule, strobed by LATCH.

Test Plan:
Use CLK_HZ=1000, FRAME_HZ=10 (TICK_DIV=100), NUM_PIXELS=8, PEAK_HOLD_FRAMES=2, i_drv_rdy=1, i_pix_ready=1 unless stated.
1. Reset: hold i_rst_n=0 over ticks -> all outputs 0, no o_drv_send. Assert reset mid-STREAM -> o_pix_valid drops asynchronously; o_frame_cnt stays 0.
2. Single sample 0x80 -> lit=4; one o_drv_send pulse; pixels 0-3 = 0x100000, pixels 4-7 = 0; o_frame_cnt=1.
3. Sample 0xFF -> pixels 0-4 = 0x100000, pixels 5-6 = 0x101000, pixel 7 = 0x001000.
4. Peak hold: 0xFF frame, then only 0x00 samples -> next two frames show only pixel 7 = 0x080808. The following frames show the dot at pixel 6, then 5, ..., then all zero.
5. Backpressure:
   - i_drv_rdy=0 for 30 cycles -> o_drv_send is delayed until i_drv_rdy rises.
   - i_pix_ready alternating -> o_pix_data stable while stalled; exactly 8 transfers.
   - A tick during a 150-cycle stall -> exactly one extra frame follows immediately.
6. Disable mid-frame: drop i_enable during STREAM -> current frame completes, then one all-zero frame, then no o_drv_send over 5 further ticks.

Source files
------------

// File: rtl/vu_pkg.sv
// rtl/vu_pkg.sv - shared state codes, colours and level-to-bar mapping for the VU meter
package vu_pkg;

    typedef logic [2:0] vu_state_t;

    localparam vu_state_t ST_IDLE     = 3'd0;
    localparam vu_state_t ST_LATCH    = 3'd1;
    localparam vu_state_t ST_WAIT_RDY = 3'd2;
    localparam vu_state_t ST_STREAM   = 3'd3;
    localparam vu_state_t ST_DONE     = 3'd4;

    // GRB order: G in [23:16], R in [15:8], B in [7:0]
    localparam logic [23:0] COL_GREEN  = 24'h100000;
    localparam logic [23:0] COL_YELLOW = 24'h101000;
    localparam logic [23:0] COL_RED    = 24'h001000;
    localparam logic [23:0] COL_PEAK   = 24'h080808;
    localparam logic [23:0] COL_OFF    = 24'h000000;

    localparam int ZONE_GREEN_NUM  = 5;
    localparam int ZONE_YELLOW_NUM = 7;
    localparam int ZONE_DEN        = 8;

    // Full-scale level maps to every pixel, zero maps to none
    function automatic int vu_lit(input int level, input int num_pixels, input int level_w);
        return ((level + 1) * num_pixels) >> level_w;
    endfunction

endpackage

// File: rtl/vu_peak_tracker.sv
// rtl/vu_peak_tracker.sv - peak-hold dot position with hold timer and one-pixel-per-frame decay
module vu_peak_tracker #(
    parameter int LIT_W            = 5,
    parameter int PEAK_HOLD_FRAMES = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             latch,
    input  logic [LIT_W-1:0] lit,
    output logic [LIT_W-1:0] peak
);

    localparam int HOLD_W = (PEAK_HOLD_FRAMES > 0) ? $clog2(PEAK_HOLD_FRAMES + 1) : 1;

    logic [HOLD_W-1:0] hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak <= '0;
            hold <= '0;
        end else if (latch) begin
            if (lit >= peak) begin
                peak <= lit;
                hold <= HOLD_W'(PEAK_HOLD_FRAMES);
            end else if (hold != '0) begin
                hold <= hold - HOLD_W'(1);
            end else if (peak != '0) begin
                peak <= peak - LIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vu_frame_scheduler.sv
// rtl/vu_frame_scheduler.sv - frame-rate sequencer turning level samples into bar-graph pixel streams
module vu_frame_scheduler
    import vu_pkg::*;
#(
    parameter int CLK_HZ           = 50_000_000,
    parameter int FRAME_HZ         = 60,
    parameter int NUM_PIXELS       = 16,
    parameter int LEVEL_W          = 8,
    parameter int PEAK_HOLD_FRAMES = 30
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [LEVEL_W-1:0] i_level,
    input  logic               i_level_valid,
    input  logic               i_enable,
    input  logic               i_drv_rdy,
    output logic               o_drv_send,
    output logic [23:0]        o_pix_data,
    output logic               o_pix_valid,
    input  logic               i_pix_ready,
    output logic               o_frame_busy,
    output logic [15:0]        o_frame_cnt
);

    localparam int TICK_DIV = CLK_HZ / FRAME_HZ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LIT_W    = $clog2(NUM_PIXELS + 1);

    localparam logic [LIT_W-1:0] LAST_IDX = LIT_W'(NUM_PIXELS - 1);
    localparam logic [LIT_W-1:0] ZONE_G   = LIT_W'(NUM_PIXELS * ZONE_GREEN_NUM / ZONE_DEN);
    localparam logic [LIT_W-1:0] ZONE_Y   = LIT_W'(NUM_PIXELS * ZONE_YELLOW_NUM / ZONE_DEN);

    vu_state_t          state;
    logic [TICK_W-1:0]  tick_cnt;
    logic               tick;
    logic [LEVEL_W-1:0] acc;
    logic [LIT_W-1:0]   lit_now;
    logic [LIT_W-1:0]   lit_q;
    logic [LIT_W-1:0]   idx;
    logic [LIT_W-1:0]   peak;
    logic               pending;
    logic               blank_req;
    logic               frame_blank;
    logic               enable_q;
    logic [15:0]        frame_cnt;
    logic               in_latch;
    logic               start_frame;
    logic [23:0]        colour;

    assign tick     = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign in_latch = (state == ST_LATCH);
    assign lit_now  = LIT_W'(vu_lit(int'(acc), NUM_PIXELS, LEVEL_W));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // A sample arriving in the LATCH cycle opens the next window
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc <= '0;
        end else if (in_latch) begin
            acc <= i_level_valid ? i_level : '0;
        end else if (i_level_valid && (i_level > acc)) begin
            acc <= i_level;
        end
    end

    always_comb begin
        start_frame = 1'b0;
        if (state == ST_IDLE) begin
            start_frame = (tick && i_enable) || blank_req;
        end else if (state == ST_DONE) begin
            start_frame = blank_req || pending || (tick && i_enable);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            lit_q       <= '0;
            idx         <= '0;
            pending     <= 1'b0;
            blank_req   <= 1'b0;
            frame_blank <= 1'b0;
            enable_q    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            enable_q <= i_enable;

            if (enable_q && !i_enable) begin
                blank_req <= 1'b1;
            end else if (i_enable || start_frame) begin
                blank_req <= 1'b0;
            end

            if (start_frame) begin
                pending <= 1'b0;
            end else if (tick && i_enable && (state != ST_IDLE)) begin
                pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_frame) begin
                        state       <= ST_LATCH;
                        frame_blank <= blank_req;
                    end
                end
                ST_LATCH: begin
                    lit_q <= lit_now;
                    state <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (i_drv_rdy) begin
                        state <= ST_STREAM;
                        idx   <= '0;
                    end
                end
                ST_STREAM: begin
                    if (i_pix_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + LIT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    if (start_frame) begin
                        state       <= ST_LATCH;
                        frame_blank <= blank_req;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Blank frames leave the peak dot where it was
    vu_peak_tracker #(
        .LIT_W            (LIT_W),
        .PEAK_HOLD_FRAMES (PEAK_HOLD_FRAMES)
    ) u_peak (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .latch (in_latch && !frame_blank),
        .lit   (lit_now),
        .peak  (peak)
    );

    always_comb begin
        colour = COL_OFF;
        if (frame_blank) begin
            colour = COL_OFF;
        end else if ((idx < lit_q) && (idx < ZONE_G)) begin
            colour = COL_GREEN;
        end else if ((idx < lit_q) && (idx < ZONE_Y)) begin
            colour = COL_YELLOW;
        end else if (idx < lit_q) begin
            colour = COL_RED;
        end else if ((peak != '0) && (idx == peak - LIT_W'(1))) begin
            colour = COL_PEAK;
        end
    end

    assign o_drv_send   = (state == ST_WAIT_RDY) && i_drv_rdy;
    assign o_pix_valid  = (state == ST_STREAM);
    assign o_pix_data   = (state == ST_STREAM) ? colour : COL_OFF;
    assign o_frame_busy = (state != ST_IDLE);
    assign o_frame_cnt  = frame_cnt;

endmodule

// File: tb/tb_vu_frame_scheduler.sv
// tb/tb_vu_frame_scheduler.sv - directed scoreboard bench for vu_frame_scheduler
module tb_vu_frame_scheduler;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_level = 8'h00;
    logic        i_level_valid = 1'b0;
    logic        i_enable = 1'b1;
    logic        i_drv_rdy = 1'b1;
    logic        o_drv_send;
    logic [23:0] o_pix_data;
    logic        o_pix_valid;
    logic        i_pix_ready = 1'b1;
    logic        o_frame_busy;
    logic [15:0] o_frame_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;
    int send_cnt = 0;
    int xfer_cnt = 0;
    logic send_prev = 1'b0;
    logic [23:0] exp_q[$];

    vu_frame_scheduler #(
        .CLK_HZ           (1000),
        .FRAME_HZ         (10),
        .NUM_PIXELS       (8),
        .LEVEL_W          (8),
        .PEAK_HOLD_FRAMES (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_level       (i_level),
        .i_level_valid (i_level_valid),
        .i_enable      (i_enable),
        .i_drv_rdy     (i_drv_rdy),
        .o_drv_send    (o_drv_send),
        .o_pix_data    (o_pix_data),
        .o_pix_valid   (o_pix_valid),
        .i_pix_ready   (i_pix_ready),
        .o_frame_busy  (o_frame_busy),
        .o_frame_cnt   (o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [23:0] exp_pix(input int i, input int lit, input int peak);
        if (i < lit && i < 5) return 24'h100000;
        if (i < lit && i < 7) return 24'h101000;
        if (i < lit) return 24'h001000;
        if (peak > 0 && i == peak - 1) return 24'h080808;
        return 24'h000000;
    endfunction

    task automatic push_frame(input int lit, input int peak);
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_pix(i, lit, peak));
    endtask

    task automatic push_blank();
        for (int i = 0; i < 8; i++) exp_q.push_back(24'h000000);
    endtask

    task automatic send_level(input logic [7:0] v);
        @(posedge i_clk); #1;
        i_level = v;
        i_level_valid = 1'b1;
        @(posedge i_clk); #1;
        i_level_valid = 1'b0;
    endtask

    task automatic wait_cnt(input string tag, input logic [15:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (o_frame_cnt === target) break;
        end
        check(tag, 32'(o_frame_cnt), 32'(target));
    endtask

    task automatic wait_busy(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (o_frame_busy === 1'b1) break;
        end
        check(tag, 32'(o_frame_busy), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (o_pix_valid === 1'b1) break;
        end
        check(tag, 32'(o_pix_valid), 32'd1);
    endtask

    // Scoreboard: every presented word must match the head of the expected queue
    always @(negedge i_clk) begin
        if (send_prev) check("valid_after_send", 32'(o_pix_valid), 32'd1);
        send_prev = o_drv_send;
        if (o_drv_send === 1'b1) send_cnt++;
        if (o_pix_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pix_unexpected", 32'(o_pix_valid), 32'd0);
            end else begin
                check("pix_data", 32'(o_pix_data), 32'(exp_q[0]));
                if (i_pix_ready) begin
                    void'(exp_q.pop_front());
                    xfer_cnt++;
                end
            end
        end
    end

    initial begin
        int s0;
        int x0;

        // Reset held across several tick periods
        for (int k = 0; k < 5; k++) begin
            repeat (50) @(negedge i_clk);
            check("rst_send", 32'(o_drv_send), 32'd0);
            check("rst_valid", 32'(o_pix_valid), 32'd0);
            check("rst_data", 32'(o_pix_data), 32'd0);
            check("rst_busy", 32'(o_frame_busy), 32'd0);
            check("rst_cnt", 32'(o_frame_cnt), 32'd0);
        end
        check("rst_no_send", 32'(send_cnt), 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Mid-scale sample lights half the bar
        send_level(8'h80);
        push_frame(4, 4);
        wait_cnt("frame_0x80", 16'd1, 300);
        check("one_send", 32'(send_cnt), 32'd1);

        // Full-scale sample covers all three zones
        send_level(8'hFF);
        push_frame(8, 8);
        wait_cnt("frame_0xff", 16'd2, 300);

        // Peak holds two frames at pixel 7, then decays one pixel per frame
        for (int p = 0; p < 10; p++) begin
            int pk;
            pk = (p < 2) ? 8 : 9 - p;
            send_level(8'h00);
            push_frame(0, pk);
            wait_cnt("frame_decay", 16'(3 + p), 300);
        end
        check("decay_queue_empty", 32'(exp_q.size()), 32'd0);

        // Driver not ready delays the send strobe
        send_level(8'h40);
        push_frame(2, 2);
        i_drv_rdy = 1'b0;
        wait_busy("rdy_busy", 300);
        s0 = send_cnt;
        repeat (30) @(negedge i_clk);
        check("send_held", 32'(send_cnt), 32'(s0));
        @(posedge i_clk); #1;
        i_drv_rdy = 1'b1;
        @(negedge i_clk);
        check("send_on_rdy", 32'(o_drv_send), 32'd1);
        wait_cnt("frame_rdy", 16'd13, 100);

        // Pixel backpressure: alternating ready
        send_level(8'hFF);
        push_frame(8, 8);
        x0 = xfer_cnt;
        for (int i = 0; i < 400; i++) begin
            @(posedge i_clk); #1;
            i_pix_ready = ~i_pix_ready;
            if (o_frame_cnt == 16'd14) break;
        end
        i_pix_ready = 1'b1;
        check("bp_frame_cnt", 32'(o_frame_cnt), 32'd14);
        check("bp_xfers", 32'(xfer_cnt - x0), 32'd8);

        // Tick during a long driver stall yields exactly one back-to-back frame
        push_frame(0, 8);
        push_frame(0, 8);
        i_drv_rdy = 1'b0;
        wait_busy("stall_busy", 300);
        repeat (150) @(negedge i_clk);
        @(posedge i_clk); #1;
        i_drv_rdy = 1'b1;
        wait_cnt("stall_frame", 16'd15, 100);
        check("extra_frame_immediate", 32'(o_frame_busy), 32'd1);
        wait_cnt("extra_frame", 16'd16, 50);
        check("no_third_frame", 32'(o_frame_busy), 32'd0);

        // Disable mid-stream: frame completes, one blank frame, then silence
        push_frame(0, 7);
        wait_valid("dis_stream", 300);
        @(posedge i_clk); #1;
        i_enable = 1'b0;
        push_blank();
        wait_cnt("dis_frames", 16'd18, 100);
        s0 = send_cnt;
        repeat (500) @(negedge i_clk);
        check("dis_no_send", 32'(send_cnt), 32'(s0));
        check("dis_cnt", 32'(o_frame_cnt), 32'd18);
        check("dis_idle", 32'(o_frame_busy), 32'd0);
        check("dis_queue_empty", 32'(exp_q.size()), 32'd0);

        // Re-enable: dot continues from where the blank frame left it
        @(posedge i_clk); #1;
        i_enable = 1'b1;
        push_frame(0, 6);
        wait_cnt("reen_frame", 16'd19, 300);

        // Asynchronous reset in the middle of a stream
        push_frame(0, 5);
        wait_valid("rst_stream", 300);
        @(posedge i_clk); #2;
        i_rst_n = 1'b0;
        #1;
        check("async_valid", 32'(o_pix_valid), 32'd0);
        check("async_busy", 32'(o_frame_busy), 32'd0);
        check("async_cnt", 32'(o_frame_cnt), 32'd0);
        exp_q.delete();
        repeat (20) @(negedge i_clk);
        check("async_cnt_hold", 32'(o_frame_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
